// File: rtl/aggregator_arbiter.sv
// aggregator_arbiter: round-robin arbiter that locks one sender FIFO onto the aggregator
// input for a burst of burst_len words; burst-length changes take effect at burst boundaries.
//
// state | meaning
// IDLE  | no grant held; pick the next non-empty sender from the rr pointer upward
// BUSY  | grant locked to out_id until the beat carrying out_last is accepted
module aggregator_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_REQ       = 4,
    parameter int MAX_BURST     = 8,
    parameter int DEFAULT_BURST = 2,
    localparam int BW = $clog2(MAX_BURST + 1),
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] sender_data,
    input  logic [NUM_REQ-1:0]            sender_empty_n,
    output logic [NUM_REQ-1:0]            sender_deq,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_empty_n,
    input  logic                          out_deq,
    output logic [IW-1:0]                 out_id,
    output logic                          out_last,
    input  logic [BW-1:0]                 input_burst_len,
    input  logic                          change_burst_len,
    output logic                          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state;
    logic [IW-1:0]         grant;
    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         grant_nxt;
    logic [IW-1:0]         pick_idx;
    logic                  pick_found;
    logic [BW-1:0]         count;
    logic [BW-1:0]         burst_len;
    logic [BW-1:0]         pend_len;
    logic                  pend_valid;
    logic [DATA_WIDTH-1:0] head [NUM_REQ];
    logic                  grant_valid;
    logic                  last_beat;
    logic                  accept;
    logic                  cfg_ok;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_head
            assign head[g] = sender_data[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // First non-empty sender at or above rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        int            j;
        logic [IW-1:0] jj;
        pick_idx   = rr_ptr;
        pick_found = 1'b0;
        j          = 0;
        jj         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = IW'(j);
            if (!pick_found && sender_empty_n[jj]) begin
                pick_found = 1'b1;
                pick_idx   = jj;
            end
        end
    end

    assign grant_nxt   = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    assign busy        = (state == BUSY);
    assign grant_valid = busy & sender_empty_n[grant];
    assign last_beat   = (count == burst_len - BW'(1));
    assign accept      = grant_valid & out_deq;
    assign cfg_ok      = change_burst_len && (input_burst_len != '0)
                         && (input_burst_len <= BW'(MAX_BURST));

    assign out_empty_n = grant_valid;
    assign out_last    = grant_valid & last_beat;
    assign out_id      = grant;
    assign out_data    = busy ? head[grant] : '0;

    always_comb begin
        sender_deq = '0;
        if (accept) begin
            sender_deq[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            count      <= '0;
            burst_len  <= BW'(DEFAULT_BURST);
            pend_len   <= '0;
            pend_valid <= 1'b0;
        end else if (state == IDLE) begin
            if (cfg_ok) begin
                burst_len <= input_burst_len;
            end
            if (pick_found) begin
                grant <= pick_idx;
                state <= BUSY;
            end
        end else begin
            if (accept && last_beat) begin
                count      <= '0;
                rr_ptr     <= grant_nxt;
                state      <= IDLE;
                pend_valid <= 1'b0;
                // A pulse coinciding with the final beat wins over an older pending value.
                if (cfg_ok) begin
                    burst_len <= input_burst_len;
                end else if (pend_valid) begin
                    burst_len <= pend_len;
                end
            end else begin
                if (accept) begin
                    count <= count + 1'b1;
                end
                if (cfg_ok) begin
                    pend_len   <= input_burst_len;
                    pend_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aggregator_arbiter.sv
// Bench for aggregator_arbiter: FIFO queues drive the senders, a burst-level reference model
// predicts every cycle, and a negedge monitor compares the DUT against the queued predictions.
module tb_aggregator_arbiter;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 8;
    localparam int DB = 2;
    localparam int BW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR*DW-1:0] sender_data = '0;
    logic [NR-1:0] sender_empty_n = '0;
    logic [NR-1:0] sender_deq;
    logic [DW-1:0] out_data;
    logic          out_empty_n;
    logic          out_deq = 1'b0;
    logic [IW-1:0] out_id;
    logic          out_last;
    logic [BW-1:0] input_burst_len = '0;
    logic          change_burst_len = 1'b0;
    logic          busy;

    always #5 clk = ~clk;

    aggregator_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .DEFAULT_BURST(DB)) dut (
        .clk(clk), .rst(rst), .sender_data(sender_data), .sender_empty_n(sender_empty_n),
        .sender_deq(sender_deq), .out_data(out_data), .out_empty_n(out_empty_n),
        .out_deq(out_deq), .out_id(out_id), .out_last(out_last),
        .input_burst_len(input_burst_len), .change_burst_len(change_burst_len), .busy(busy)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic          busy;
        logic          valid;
        logic          last;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [NR-1:0] deq;
    } ctl_t;

    beat_t         exp_beats[$];
    ctl_t          exp_ctl[$];
    beat_t         got_log[$];
    logic [DW-1:0] fifo[NR][$];
    int            seq[NR];
    int            compared = 0;
    int            mismatched = 0;

    // Reference model: burst-level view of the arbiter.
    bit m_busy;
    int m_id, m_left, m_rr, m_len, m_pend;
    bit m_pend_v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    ctl_t  mon_c;
    beat_t mon_b;
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_ctl.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL ctl_queue: got empty expected a prediction at %0t", $time);
            end else begin
                mon_c = exp_ctl.pop_front();
                check("busy", busy, mon_c.busy);
                check("out_empty_n", out_empty_n, mon_c.valid);
                check("out_last", out_last, mon_c.last);
                check("out_data", out_data, mon_c.data);
                check("sender_deq", sender_deq, mon_c.deq);
                if (mon_c.busy) check("out_id", out_id, mon_c.id);
            end
            if (out_empty_n && out_deq) begin
                got_log.push_back({out_id, out_data, out_last});
                if (exp_beats.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL beat_queue: got beat %0h expected none at %0t", out_data, $time);
                end else begin
                    mon_b = exp_beats.pop_front();
                    check("beat_id", out_id, mon_b.id);
                    check("beat_data", out_data, mon_b.data);
                    check("beat_last", out_last, mon_b.last);
                end
            end
        end
    end

    function automatic int pick();
        for (int k = 0; k < NR; k++) begin
            if (fifo[(m_rr + k) % NR].size() > 0) return (m_rr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_id = 0; m_left = 0; m_rr = 0; m_len = DB; m_pend = 0; m_pend_v = 0;
    endtask

    task automatic load(input int i, input int base, input int n);
        for (int k = 0; k < n; k++) fifo[i].push_back(DW'(base + k));
    endtask

    // Drives one cycle at posedge+1, queues the prediction, then advances the model past the edge.
    task automatic cycle(input bit deq, input bit cfg, input int cfg_len);
        ctl_t  c;
        beat_t b;
        bit    valid, acc, lst, cfg_ok;
        int    nxt;
        out_deq          = deq;
        change_burst_len = cfg;
        input_burst_len  = BW'(cfg_len);
        for (int i = 0; i < NR; i++) begin
            sender_empty_n[i]         = fifo[i].size() > 0;
            sender_data[i*DW +: DW]   = (fifo[i].size() > 0) ? fifo[i][0] : '0;
        end
        valid   = m_busy && fifo[m_id].size() > 0;
        acc     = valid && deq;
        lst     = valid && m_left == 1;
        c.busy  = m_busy;
        c.valid = valid;
        c.last  = lst;
        c.id    = IW'(m_id);
        c.data  = valid ? fifo[m_id][0] : '0;
        c.deq   = acc ? NR'(1 << m_id) : '0;
        exp_ctl.push_back(c);
        if (acc) begin
            b.id = IW'(m_id); b.data = fifo[m_id][0]; b.last = lst;
            exp_beats.push_back(b);
        end
        cfg_ok = cfg && cfg_len >= 1 && cfg_len <= MB;
        @(posedge clk);
        #1;
        if (!m_busy) begin
            if (cfg_ok) m_len = cfg_len;
            nxt = pick();
            if (nxt >= 0) begin
                m_busy = 1; m_id = nxt; m_left = m_len;
            end
        end else if (acc && lst) begin
            void'(fifo[m_id].pop_front());
            m_busy = 0;
            m_rr = (m_id + 1) % NR;
            if (cfg_ok) m_len = cfg_len;
            else if (m_pend_v) m_len = m_pend;
            m_pend_v = 0;
        end else begin
            if (acc) begin
                void'(fifo[m_id].pop_front());
                m_left--;
            end
            if (cfg_ok) begin
                m_pend = cfg_len; m_pend_v = 1;
            end
        end
    endtask

    task automatic do_reset(input bit clear_fifos);
        out_deq = 0; change_burst_len = 0;
        rst = 1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_out_empty_n", out_empty_n, 0);
        check("rst_sender_deq", sender_deq, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_id", out_id, 0);
        check("rst_pending_beats", exp_beats.size(), 0);
        exp_ctl.delete();
        model_reset();
        if (clear_fifos) for (int i = 0; i < NR; i++) fifo[i].delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        got_log.delete();
    endtask

    initial begin
        logic [DW-1:0] t2_exp [9];
        bit            drained;
        t2_exp = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02};
        model_reset();
        @(posedge clk);
        #1;

        // 1) single requester, burst 2, continuous pop
        do_reset(1);
        load(0, 0, 6);
        for (int k = 0; k < 12; k++) cycle(1, 0, 0);
        check("t1_count", got_log.size(), 6);
        for (int k = 0; k < 6 && k < got_log.size(); k++) begin
            check("t1_data", got_log[k].data, k);
            check("t1_last", got_log[k].last, k % 2);
            check("t1_id", got_log[k].id, 0);
        end

        // 2) all four requesters, round-robin order
        do_reset(1);
        for (int i = 0; i < NR; i++) load(i, i * 16, 4);
        for (int k = 0; k < 16; k++) cycle(1, 0, 0);
        check("t2_count_min", got_log.size() >= 9, 1);
        for (int k = 0; k < 9 && k < got_log.size(); k++) begin
            check("t2_data", got_log[k].data, t2_exp[k]);
            check("t2_id", got_log[k].id, t2_exp[k] >> 4);
        end

        // 3) granted FIFO runs dry mid-burst; grant stays locked
        do_reset(1);
        cycle(0, 1, 3);
        load(1, 8'h50, 1);
        load(2, 8'h60, 4);
        for (int k = 0; k < 6; k++) cycle(1, 0, 0);
        load(1, 8'h51, 2);
        for (int k = 0; k < 10; k++) cycle(1, 0, 0);
        check("t3_count_min", got_log.size() >= 4, 1);
        for (int k = 0; k < 3 && k < got_log.size(); k++) check("t3_id1", got_log[k].id, 1);
        if (got_log.size() >= 4) check("t3_then_id2", got_log[3].id, 2);

        // 4) mid-burst change to 4 deferred; 0 and 9 ignored
        do_reset(1);
        load(0, 0, 16);
        for (int k = 0; k < 14; k++) begin
            if (k == 1) cycle(1, 1, 4);
            else if (k == 4) cycle(1, 1, 0);
            else if (k == 6) cycle(1, 1, 9);
            else cycle(1, 0, 0);
        end
        check("t4_count_min", got_log.size() >= 10, 1);
        for (int k = 0; k < 10 && k < got_log.size(); k++)
            check("t4_last", got_log[k].last, (k == 1 || k == 5 || k == 9));

        // 5) reset mid-burst, burst_len returns to default, rr restarts at 0
        do_reset(1);
        load(0, 0, 8);
        cycle(0, 1, 4);
        cycle(1, 0, 0);
        do_reset(0);
        load(1, 8'h40, 4);
        for (int k = 0; k < 10; k++) cycle(1, 0, 0);
        check("t5_count_min", got_log.size() >= 2, 1);
        if (got_log.size() >= 2) begin
            check("t5_first_id", got_log[0].id, 0);
            check("t5_first_data", got_log[0].data, 1);
            check("t5_second_last", got_log[1].last, 1);
        end

        // 6) random pushes, pops and config pulses
        do_reset(1);
        for (int i = 0; i < NR; i++) seq[i] = 0;
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 99) < 25 && fifo[i].size() < 8) begin
                    fifo[i].push_back(DW'((i << 6) | (seq[i] & 63)));
                    seq[i]++;
                end
            end
            if ($urandom_range(0, 99) < 4) cycle($urandom_range(0, 99) < 60, 1, $urandom_range(0, 10));
            else cycle($urandom_range(0, 99) < 60, 0, 0);
        end
        drained = 0;
        for (int k = 0; k < 300 && !drained; k++) begin
            cycle(1, 0, 0);
            drained = !m_busy && fifo[0].size() == 0 && fifo[1].size() == 0
                      && fifo[2].size() == 0 && fifo[3].size() == 0;
        end
        check("t6_drained", drained, 1);
        check("t6_beats_left", exp_beats.size(), 0);
        check("t6_ctl_left", exp_ctl.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
